modn_count_ctrl: RTL and testbench
==================================

Name: modn_count_ctrl

Overview:
- Run-control sequencer for a mod-N counting datapath.
- Accepts a runtime modulus through a valid/ready config handshake, then starts and stops counting.
- Runs in periodic or one-shot mode and reports wrap events and completion.
- Sits between a register/CPU-style config agent and downstream logic that consumes count values and wrap ticks.

Parameters:
- WIDTH, 8, bit-width of count and modulus.
- DEF_MOD, 10, modulus in effect after reset until the first accepted config; must satisfy 1 <= DEF_MOD <= 2^WIDTH.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; one clock, asynchronous and active-low.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  controller can accept config.
- cfg_mod  in  WIDTH  new modulus; 0 encodes 2^WIDTH.
- cfg_oneshot  in  1  1 = stop after one full period, 0 = periodic.
- start  in  1  single-cycle start request.
- stop  in  1  single-cycle abort request.
- count  out  WIDTH  current count value.
- wrap  out  1  one-cycle pulse; count just returned to 0 from mod-1.
- busy  out  1  state == RUN.
- done  out  1  one-shot period completed; sticky.

Behaviour:
- Reset values:
  - count=0, wrap=0, busy=0, done=0, cfg_ready=1.
  - State IDLE, modulus=DEF_MOD, oneshot=0.
- FSM states: IDLE, RUN, DONE.
- cfg_ready=1 in IDLE and DONE, 0 in RUN.
- Config transfer occurs on an edge where cfg_valid && cfg_ready.
  - Latches cfg_mod and cfg_oneshot.
  - Clears done; DONE goes to IDLE.
  - count is unchanged (already 0).
- Effective modulus M = (mod==0) ? 2^WIDTH : mod. The internal compare uses a WIDTH+1-bit term, or equivalently compares count against mod-1 in WIDTH bits with wrap-around, so mod=0 compares against all-ones.
- IDLE/DONE + start:
  - Goes to RUN on the next edge with count=0 and done cleared.
  - First increment on the following edge, so the count sequence from the start cycle is 0,0,1,2,...
- Same-cycle start and config in IDLE/DONE: the config is latched and used by the starting run.
- RUN, each edge with no stop:
  - If count==M-1: count<=0 and wrap<=1.
  - Else: count<=count+1 and wrap<=0.
- Wrap in one-shot mode: the wrap edge also moves the FSM to DONE and sets done=1. The final count is 0.
- M==1: count stays 0 and wrap pulses every cycle in RUN. In one-shot, DONE follows after one RUN cycle.
- RUN + stop:
  - Goes to IDLE on the next edge; count<=0, wrap<=0, done unchanged (0).
  - stop has priority over a same-cycle wrap: no wrap pulse, no done.
- start and stop in the same cycle: stop wins in every state; in IDLE/DONE both are ignored.
- start while in RUN: ignored (no restart).
- stop in IDLE/DONE: no effect; done remains set.
- cfg_valid while in RUN: held off by cfg_ready=0; the requester keeps cfg_valid and cfg_mod stable until the transfer.
- Asynchronous reset mid-run: immediately returns all outputs and state to reset values, including modulus=DEF_MOD.
- Latency: wrap and done are registered and coincide with count showing 0 after the terminal value.

Optional Feature:
- Macro: MODN_COUNT_CTRL_PRESCALE_EN.
- When defined:
  - Adds port cfg_pre (in, 8) and an 8-bit prescaler, latched with the config.
  - In RUN the count advances only on edges where the prescaler equals cfg_pre, so it advances once every cfg_pre+1 cycles.
  - The prescaler resets to 0 on start, stop, wrap and reset.
  - wrap and done follow the advancing edge.
  - cfg_pre resets to 0.
- When undefined: no port, and the count advances every RUN cycle (identical to cfg_pre=0).

Decomposition:
- Package modn_count_ctrl_pkg holds:
  - state enum typedef (IDLE, RUN, DONE);
  - localparam for the prescaler width (8);
  - a function computing the terminal value M-1 from mod and WIDTH.
- One natural sub-module, modn_count_core: the counter register with increment, enable, clear, load-terminal and wrap output. The FSM and handshake live in modn_count_ctrl.

Test Plan:
- Reset, then start with no config → DEF_MOD=10 periodic: count 0,0,1..9,0,1...; wrap high when count returns to 0; busy=1; done=0.
- Config mod=3, oneshot=1, then start → count 0,0,1,2,0; done=1 and wrap=1 on the same cycle; state DONE; cfg_ready=1; done stays set until the next start or config.
- Start with mod=5, assert cfg_valid mid-run → cfg_ready=0 and no transfer; stop at count=4 (same cycle as wrap) → count=0, no wrap, IDLE; then config transfers.
- mod=1 periodic → wrap every cycle with count=0. mod=0 with WIDTH=8 → count reaches 255, then wrap to 0.
- start and stop in the same cycle from IDLE → stays IDLE. Assert rst_n low between clock edges mid-run with mod=7 → count=0 and busy=0 immediately; the next start runs with mod=10.
- With MODN_COUNT_CTRL_PRESCALE_EN defined and cfg_pre=2, mod=4 → count advances every 3 cycles; wrap after 12 RUN cycles.

Source files
------------

// File: rtl/modn_count_ctrl_pkg.sv
// Purpose : shared types and helpers for the mod-N run-control sequencer.
// Latency : n/a (types, constants and a combinational helper only).
// Backpr. : n/a.
// Optional feature macro: MODN_COUNT_CTRL_PRESCALE_EN (uses PRE_W).
package modn_count_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the optional prescaler and its reload value.
    localparam int PRE_W = 8;

    // Terminal count M-1 for a modulus field of 'width' bits. A modulus of 0
    // encodes 2^width, so subtracting 1 and masking to 'width' bits yields
    // all-ones for that case. Assumes width <= 32.
    function automatic logic [31:0] term_of(input logic [31:0] mod, input int width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (mod - 32'd1) & mask;
    endfunction

endpackage

// File: rtl/modn_count_ctrl_if.sv
// Purpose : config handshake bundle between a config agent and the sequencer.
// Latency : n/a (wires only).
// Backpr. : cfg_ready low holds the requester; it keeps cfg_valid/cfg_mod stable.
// Signals : cfg_valid, cfg_ready, cfg_mod[WIDTH], cfg_oneshot,
//           cfg_pre[PRE_W] only when MODN_COUNT_CTRL_PRESCALE_EN is defined.
interface modn_count_ctrl_if
    import modn_count_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_mod;
    logic             cfg_oneshot;
`ifdef MODN_COUNT_CTRL_PRESCALE_EN
    logic [PRE_W-1:0] cfg_pre;

    modport master (output cfg_valid, cfg_mod, cfg_oneshot, cfg_pre, input cfg_ready);
    modport slave  (input cfg_valid, cfg_mod, cfg_oneshot, cfg_pre, output cfg_ready);
`else
    modport master (output cfg_valid, cfg_mod, cfg_oneshot, input cfg_ready);
    modport slave  (input cfg_valid, cfg_mod, cfg_oneshot, output cfg_ready);
`endif
endinterface

// File: rtl/modn_count_core.sv
// Purpose : count register with clear, enable and terminal compare; pulses wrap on return to 0.
// Latency : count and wrap are registered, updating one edge after clr/en.
// Backpr. : none; the caller gates advancement through en.
// Ports   : clk, rst_n, clr, en, term[WIDTH] -> count[WIDTH], wrap, at_term (comb).
module modn_count_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_term
);

    assign at_term = (count == term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (en) begin
            if (at_term) begin
                count <= '0;
                wrap  <= 1'b1;
            end else begin
                count <= count + WIDTH'(1);
                wrap  <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/modn_count_ctrl.sv
// Purpose : run-control FSM (IDLE/RUN/DONE) for a mod-N counter, periodic or one-shot.
// Latency : count/wrap/done/busy/cfg_ready registered; first increment two edges after start.
// Backpr. : cfg_ready is low while running, so config requests wait until IDLE/DONE.
// Ports   : clk, rst_n, cfg (slave modport), start, stop -> count[WIDTH], wrap, busy, done.
// Optional: MODN_COUNT_CTRL_PRESCALE_EN adds cfg.cfg_pre and an advance prescaler.
module modn_count_ctrl
    import modn_count_ctrl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEF_MOD = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    modn_count_ctrl_if.slave cfg,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [WIDTH-1:0] mod_q;
    logic             oneshot_q;
    logic             ready_q;
    logic [WIDTH-1:0] term;
    logic             xfer;
    logic             go;
    logic             clr;
    logic             en;
    logic             adv;
    logic             at_term;

    assign term = WIDTH'(term_of(32'(mod_q), WIDTH));
    assign xfer = cfg.cfg_valid && ready_q;
    // stop beats start in every state.
    assign go   = (state != RUN) && start && !stop;
    assign clr  = go || ((state == RUN) && stop);
    assign en   = (state == RUN) && !stop && adv;

`ifdef MODN_COUNT_CTRL_PRESCALE_EN
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_cnt;

    assign adv = (pre_cnt == pre_q);

    // Restarts on every advance (which includes wrap) and on start/stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (clr || en) begin
            pre_cnt <= '0;
        end else if (state == RUN) begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end
`else
    assign adv = 1'b1;
`endif

    modn_count_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .en      (en),
        .term    (term),
        .count   (count),
        .wrap    (wrap),
        .at_term (at_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mod_q     <= WIDTH'(DEF_MOD);
            oneshot_q <= 1'b0;
            ready_q   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef MODN_COUNT_CTRL_PRESCALE_EN
            pre_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (xfer) begin
                        mod_q     <= cfg.cfg_mod;
                        oneshot_q <= cfg.cfg_oneshot;
`ifdef MODN_COUNT_CTRL_PRESCALE_EN
                        pre_q     <= cfg.cfg_pre;
`endif
                        done      <= 1'b0;
                        state     <= IDLE;
                    end
                    // A same-cycle config is already latched for this run.
                    if (go) begin
                        state   <= RUN;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        ready_q <= 1'b1;
                    end else if (en && at_term && oneshot_q) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cfg.cfg_ready = ready_q;

endmodule

// File: tb/tb_modn_count_ctrl.sv
// Purpose : self-checking bench for modn_count_ctrl with a reference model and scoreboard queue.
// Latency : expectations are pushed before each edge and popped #1 after it.
// Backpr. : exercises cfg_valid held against cfg_ready=0 during RUN.
module tb_modn_count_ctrl;

    typedef struct {
        logic [7:0] count;
        logic       wrap;
        logic       busy;
        logic       done;
        logic       rdy;
    } exp_t;

    typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] count;
    logic       wrap;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    // Reference model state
    mstate_t m_st;
    int      m_mod;
    bit      m_one;
    int      m_cnt;
    bit      m_wrap;
    bit      m_done;
    int      m_pre;
    int      m_prec;

    modn_count_ctrl_if #(.WIDTH(8)) cif ();

    modn_count_ctrl #(.WIDTH(8), .DEF_MOD(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cfg   (cif.slave),
        .start (start),
        .stop  (stop),
        .count (count),
        .wrap  (wrap),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_mod = 10; m_one = 0; m_cnt = 0;
        m_wrap = 0; m_done = 0; m_pre = 0; m_prec = 0;
    endtask

    // Spec-level behaviour for one rising edge, from the inputs currently driven.
    task automatic model_edge();
        int M;
        M = (m_mod == 0) ? 256 : m_mod;
        if (m_st == M_RUN) begin
            if (stop) begin
                m_st = M_IDLE; m_cnt = 0; m_wrap = 0; m_prec = 0;
            end else if (m_prec == m_pre) begin
                m_prec = 0;
                if (m_cnt == M - 1) begin
                    m_cnt = 0; m_wrap = 1;
                    if (m_one) begin m_st = M_DONE; m_done = 1; end
                end else begin
                    m_cnt = m_cnt + 1; m_wrap = 0;
                end
            end else begin
                m_prec = m_prec + 1; m_wrap = 0;
            end
        end else begin
            m_wrap = 0;
            if (cif.cfg_valid) begin
                m_mod = int'(cif.cfg_mod); m_one = cif.cfg_oneshot; m_done = 0; m_st = M_IDLE;
`ifdef MODN_COUNT_CTRL_PRESCALE_EN
                m_pre = int'(cif.cfg_pre);
`endif
            end
            if (start && !stop) begin
                m_st = M_RUN; m_done = 0; m_cnt = 0; m_prec = 0;
            end
        end
    endtask

    // Drive-side: predict and push; output-side: pop after the edge and compare.
    task automatic step();
        exp_t e;
        model_edge();
        e.count = 8'(m_cnt);
        e.wrap  = m_wrap;
        e.busy  = (m_st == M_RUN);
        e.done  = m_done;
        e.rdy   = (m_st != M_RUN);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("count", 32'(count), 32'(e.count));
        chk("wrap", 32'(wrap), 32'(e.wrap));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("cfg_ready", 32'(cif.cfg_ready), 32'(e.rdy));
    endtask

    task automatic cfg_set(input logic v, input logic [7:0] mod, input logic one, input logic [7:0] pre);
        cif.cfg_valid   = v;
        cif.cfg_mod     = mod;
        cif.cfg_oneshot = one;
`ifdef MODN_COUNT_CTRL_PRESCALE_EN
        cif.cfg_pre     = pre;
`else
        if (pre != 8'd0) $display("note: prescale value ignored in this build");
`endif
    endtask

    initial begin
        int nwr;
        int maxc;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_set(1'b0, 8'd0, 1'b0, 8'd0);
        model_reset();
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(cif.cfg_ready), 32'd1);
        rst_n = 1'b1;

        // Default modulus, periodic
        start = 1'b1; step(); start = 1'b0;
        nwr = 0;
        for (int i = 0; i < 24; i++) begin step(); if (wrap) nwr++; end
        chk("dflt_wraps", 32'(nwr), 32'd2);
        stop = 1'b1; step(); stop = 1'b0;

        // One-shot mod=3
        cfg_set(1'b1, 8'd3, 1'b1, 8'd0); step(); cfg_set(1'b0, 8'd3, 1'b1, 8'd0);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        stop = 1'b1; step(); stop = 1'b0;
        chk("oneshot_done_sticky", 32'(done), 32'd1);

        // mod=5 with same-cycle config+start, config held off mid-run, stop on wrap cycle
        cfg_set(1'b1, 8'd5, 1'b0, 8'd0); start = 1'b1; step(); start = 1'b0;
        cfg_set(1'b0, 8'd5, 1'b0, 8'd0); step();
        cfg_set(1'b1, 8'd2, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) step();
        chk("held_count4", 32'(count), 32'd4);
        stop = 1'b1; step(); stop = 1'b0;
        step();
        cfg_set(1'b0, 8'd2, 1'b0, 8'd0);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        stop = 1'b1; step(); stop = 1'b0;

        // mod=1 periodic
        cfg_set(1'b1, 8'd1, 1'b0, 8'd0); start = 1'b1; step(); start = 1'b0;
        cfg_set(1'b0, 8'd1, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) step();
        chk("mod1_wrap", 32'(wrap), 32'd1);
        stop = 1'b1; step(); stop = 1'b0;

        // mod=0 encodes 256
        cfg_set(1'b1, 8'd0, 1'b0, 8'd0); start = 1'b1; step(); start = 1'b0;
        cfg_set(1'b0, 8'd0, 1'b0, 8'd0);
        nwr = 0; maxc = 0;
        for (int i = 0; i < 260; i++) begin
            step();
            if (wrap) nwr++;
            if (int'(count) > maxc) maxc = int'(count);
        end
        chk("mod0_max", 32'(maxc), 32'd255);
        chk("mod0_wraps", 32'(nwr), 32'd1);
        stop = 1'b1; step(); stop = 1'b0;

        // start and stop together from IDLE
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        step();

        // Async reset mid-run with mod=7, then default modulus again
        cfg_set(1'b1, 8'd7, 1'b0, 8'd0); start = 1'b1; step(); start = 1'b0;
        cfg_set(1'b0, 8'd7, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(cif.cfg_ready), 32'd1);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        nwr = 0;
        for (int i = 0; i < 12; i++) begin step(); if (wrap) nwr++; end
        chk("post_rst_wraps", 32'(nwr), 32'd1);
        stop = 1'b1; step(); stop = 1'b0;

`ifdef MODN_COUNT_CTRL_PRESCALE_EN
        // Prescaler: mod=4, pre=2 -> wrap after 12 RUN edges
        cfg_set(1'b1, 8'd4, 1'b0, 8'd2); start = 1'b1; step(); start = 1'b0;
        cfg_set(1'b0, 8'd4, 1'b0, 8'd2);
        nwr = 0;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (wrap && nwr == 0) nwr = i;
        end
        chk("pre_wrap_edge", 32'(nwr), 32'd12);
        stop = 1'b1; step(); stop = 1'b0;
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
